// File: rtl/aes_core_arbiter_if.sv
// aes_core_arbiter_if
// Bundles the two requester channels and the AES datapath host-side port
// used by aes_core_arbiter.
//   master : requesters plus datapath side (drives req/valid/data/ready,
//            core_rd_data, core_end)
//   slave  : the arbiter (drives gnt/ready/valid/data, core write/read
//            controls, core_start, err)
interface aes_core_arbiter_if;
    logic        ch0_req;
    logic        ch0_gnt;
    logic        ch0_in_valid;
    logic [31:0] ch0_in_data;
    logic        ch0_in_ready;
    logic        ch0_out_valid;
    logic [31:0] ch0_out_data;
    logic        ch0_out_ready;

    logic        ch1_req;
    logic        ch1_gnt;
    logic        ch1_in_valid;
    logic [31:0] ch1_in_data;
    logic        ch1_in_ready;
    logic        ch1_out_valid;
    logic [31:0] ch1_out_data;
    logic        ch1_out_ready;

    logic [31:0] core_wr_data;
    logic [3:0]  core_col_en;
    logic [1:0]  core_rd_sel;
    logic [31:0] core_rd_data;
    logic        core_start;
    logic        core_end;
    logic        err;

    modport master (
        output ch0_req, ch0_in_valid, ch0_in_data, ch0_out_ready,
        output ch1_req, ch1_in_valid, ch1_in_data, ch1_out_ready,
        output core_rd_data, core_end,
        input  ch0_gnt, ch0_in_ready, ch0_out_valid, ch0_out_data,
        input  ch1_gnt, ch1_in_ready, ch1_out_valid, ch1_out_data,
        input  core_wr_data, core_col_en, core_rd_sel, core_start, err
    );

    modport slave (
        input  ch0_req, ch0_in_valid, ch0_in_data, ch0_out_ready,
        input  ch1_req, ch1_in_valid, ch1_in_data, ch1_out_ready,
        input  core_rd_data, core_end,
        output ch0_gnt, ch0_in_ready, ch0_out_valid, ch0_out_data,
        output ch1_gnt, ch1_in_ready, ch1_out_valid, ch1_out_data,
        output core_wr_data, core_col_en, core_rd_sel, core_start, err
    );
endinterface

// File: rtl/aes_core_arbiter.sv
// aes_core_arbiter
// Shares one AES datapath between two word-serial requesters. A grant covers
// one whole block: 4 column writes, a start pulse, a wait for end_aes, then
// 4 column reads. Grants alternate round-robin when both channels request.
// Ports:
//   clk   : rising-edge clock
//   rst_n : synchronous active-low reset
//   bus   : aes_core_arbiter_if.slave (channel handshakes, datapath port, err)
// Parameters:
//   TIMEOUT : WAIT cycles allowed before abort (timeout build only)
//   TMR_W   : wait counter width, must hold TIMEOUT
// Optional feature: define AES_ARB_TIMEOUT_EN to abort a block whose end_aes
// never arrives; err then flags the abort until the next grant.
module aes_core_arbiter #(
    parameter int TIMEOUT = 64,
    parameter int TMR_W   = 7
) (
    input  logic              clk,
    input  logic              rst_n,
    aes_core_arbiter_if.slave bus
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_START  = 3'd2,
        ST_WAIT   = 3'd3,
        ST_UNLOAD = 3'd4
    } state_t;

    state_t      state_r, state_s;
    logic [1:0]  idx_r, idx_s;
    logic        gnt0_r, gnt0_s;
    logic        gnt1_r, gnt1_s;
    logic        ptr_r, ptr_s;      // 0: ch0 has priority, 1: ch1
    logic        start_r, start_s;

    logic        load_s, unload_s;
    logic        sel_in_valid_s, sel_out_ready_s;
    logic [31:0] sel_in_data_s;
    logic        in_hs_s, out_hs_s;

`ifdef AES_ARB_TIMEOUT_EN
    logic [TMR_W-1:0] timer_r, timer_s;
    logic             err_r, err_s;
    logic             expire_s;

    // The WAIT cycle being counted now is the TIMEOUT-th one.
    assign expire_s = ((timer_r + TMR_W'(1)) == TMR_W'(TIMEOUT));
    assign bus.err  = err_r;
`else
    // Parameters only matter for the timeout build; fold them into a sink.
    logic unused_tmr_cfg_s;
    assign unused_tmr_cfg_s = ^{TIMEOUT, TMR_W};
    assign bus.err          = 1'b0;
`endif

    // Only one gnt is ever high, so gnt1_r alone selects the active channel.
    assign load_s          = (state_r == ST_LOAD);
    assign unload_s        = (state_r == ST_UNLOAD);
    assign sel_in_valid_s  = gnt1_r ? bus.ch1_in_valid  : bus.ch0_in_valid;
    assign sel_in_data_s   = gnt1_r ? bus.ch1_in_data   : bus.ch0_in_data;
    assign sel_out_ready_s = gnt1_r ? bus.ch1_out_ready : bus.ch0_out_ready;
    assign in_hs_s         = load_s & sel_in_valid_s;
    assign out_hs_s        = unload_s & sel_out_ready_s;

    assign bus.ch0_gnt       = gnt0_r;
    assign bus.ch1_gnt       = gnt1_r;
    assign bus.ch0_in_ready  = load_s & gnt0_r;
    assign bus.ch1_in_ready  = load_s & gnt1_r;
    assign bus.ch0_out_valid = unload_s & gnt0_r;
    assign bus.ch1_out_valid = unload_s & gnt1_r;
    assign bus.ch0_out_data  = (unload_s & gnt0_r) ? bus.core_rd_data : 32'h0000_0000;
    assign bus.ch1_out_data  = (unload_s & gnt1_r) ? bus.core_rd_data : 32'h0000_0000;
    assign bus.core_col_en   = in_hs_s ? (4'b0001 << idx_r) : 4'b0000;
    assign bus.core_wr_data  = in_hs_s ? sel_in_data_s : 32'h0000_0000;
    assign bus.core_rd_sel   = unload_s ? idx_r : 2'd0;
    assign bus.core_start    = start_r;

    // Next-state and next-register values for the block transaction sequencer.
    always_comb begin
        state_s = state_r;
        idx_s   = idx_r;
        gnt0_s  = gnt0_r;
        gnt1_s  = gnt1_r;
        ptr_s   = ptr_r;
        start_s = 1'b0;
`ifdef AES_ARB_TIMEOUT_EN
        timer_s = timer_r;
        err_s   = err_r;
`endif
        case (state_r)
            ST_IDLE: begin
                if (bus.ch0_req | bus.ch1_req) begin
                    if (bus.ch0_req & bus.ch1_req) begin
                        gnt1_s = ptr_r;
                        gnt0_s = ~ptr_r;
                    end else begin
                        gnt1_s = bus.ch1_req;
                        gnt0_s = bus.ch0_req;
                    end
                    idx_s   = 2'd0;
                    state_s = ST_LOAD;
`ifdef AES_ARB_TIMEOUT_EN
                    err_s   = 1'b0;
`endif
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_LOAD: begin
                if (in_hs_s) begin
                    idx_s = idx_r + 2'd1;   // wraps to 0 after column 3
                    if (idx_r == 2'd3) begin
                        state_s = ST_START;
                        start_s = 1'b1;     // registered: high exactly in START
                    end else begin
                        state_s = ST_LOAD;
                    end
                end else begin
                    state_s = ST_LOAD;
                end
            end
            ST_START: begin
                state_s = ST_WAIT;
`ifdef AES_ARB_TIMEOUT_EN
                timer_s = {TMR_W{1'b0}};
`endif
            end
            ST_WAIT: begin
                // end_aes has priority over a simultaneous expiry.
                if (bus.core_end) begin
                    state_s = ST_UNLOAD;
                end else begin
`ifdef AES_ARB_TIMEOUT_EN
                    timer_s = timer_r + TMR_W'(1);
                    if (expire_s) begin
                        state_s = ST_IDLE;
                        gnt0_s  = 1'b0;
                        gnt1_s  = 1'b0;
                        ptr_s   = gnt0_r;
                        idx_s   = 2'd0;
                        err_s   = 1'b1;
                    end else begin
                        state_s = ST_WAIT;
                    end
`else
                    state_s = ST_WAIT;
`endif
                end
            end
            ST_UNLOAD: begin
                if (out_hs_s) begin
                    idx_s = idx_r + 2'd1;
                    if (idx_r == 2'd3) begin
                        state_s = ST_IDLE;
                        gnt0_s  = 1'b0;
                        gnt1_s  = 1'b0;
                        ptr_s   = gnt0_r;   // hand priority to the other channel
                    end else begin
                        state_s = ST_UNLOAD;
                    end
                end else begin
                    state_s = ST_UNLOAD;
                end
            end
            default: begin
                state_s = ST_IDLE;
                idx_s   = 2'd0;
                gnt0_s  = 1'b0;
                gnt1_s  = 1'b0;
            end
        endcase
    end

    // State, word index, grants, priority pointer, start pulse (and timer/err).
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
            idx_r   <= 2'd0;
            gnt0_r  <= 1'b0;
            gnt1_r  <= 1'b0;
            ptr_r   <= 1'b0;
            start_r <= 1'b0;
`ifdef AES_ARB_TIMEOUT_EN
            timer_r <= {TMR_W{1'b0}};
            err_r   <= 1'b0;
`endif
        end else begin
            state_r <= state_s;
            idx_r   <= idx_s;
            gnt0_r  <= gnt0_s;
            gnt1_r  <= gnt1_s;
            ptr_r   <= ptr_s;
            start_r <= start_s;
`ifdef AES_ARB_TIMEOUT_EN
            timer_r <= timer_s;
            err_r   <= err_s;
`endif
        end
    end

endmodule

// File: tb/tb_aes_core_arbiter.sv
// tb_aes_core_arbiter
// Randomized and directed stimulus for aes_core_arbiter, checked every cycle
// against a transaction-progress model (owner, words loaded, started, ended,
// words unloaded), plus literal expectations for the directed scenarios.
module tb_aes_core_arbiter;
    localparam int TIMEOUT = 64;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    aes_core_arbiter_if bus ();
    aes_core_arbiter #(.TIMEOUT(TIMEOUT), .TMR_W(7)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    // Stand-in for the datapath result columns.
    logic [31:0] result_mem [4];
    assign bus.core_rd_data = result_mem[bus.core_rd_sel];

    int checks = 0;
    int errors = 0;

    // Model of transaction progress
    bit m_valid = 1'b0;
    int m_owner, m_loaded, m_unloaded, m_ptr, m_waitc;
    bit m_started, m_ended, m_err;
    int done_cnt = 0;

    // Current inputs and stimulus knobs
    bit req[2], valid[2], ready[2];
    logic [31:0] din[2];
    bit cend;
    bit k_rst = 1'b0;
    int k_req[2] = '{0, 0};
    int p_valid = 100, p_ready = 100, end_delay = -1, stall_left = 0;
    bit fixed_words = 1'b0;
    logic [31:0] test_words [4];

    // Observations of the DUT for literal checks
    logic [3:0]  col_q[$];
    logic [31:0] data_q[$];
    logic [31:0] out_q[$];
    int gnt_q[$];
    int start_cnt = 0, g0_cycles = 0, stall_cnt = 0;
    bit prev_g0 = 1'b0, prev_g1 = 1'b0, last_err = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic clear_obs();
        col_q.delete(); data_q.delete(); out_q.delete(); gnt_q.delete();
        start_cnt = 0; g0_cycles = 0; stall_cnt = 0;
    endtask

    task automatic drive();
        rst_n = k_rst;
        for (int c = 0; c < 2; c++) begin
            req[c]   = (k_req[c] == 2) ? bit'($urandom_range(0, 1)) : bit'(k_req[c]);
            valid[c] = ($urandom_range(0, 99) < p_valid);
            ready[c] = ($urandom_range(0, 99) < p_ready);
            din[c]   = (fixed_words && m_owner == c && m_loaded < 4) ? test_words[m_loaded] : $urandom();
        end
        if (stall_left > 0 && m_owner == 0 && m_ended && m_unloaded == 1) begin
            ready[0] = 1'b0;
            stall_left--;
        end
        if (end_delay >= 0)       cend = m_started && !m_ended && (m_waitc >= end_delay);
        else if (end_delay == -1) cend = ($urandom_range(0, 9) == 0);
        else                      cend = 1'b0;
        bus.ch0_req = req[0]; bus.ch0_in_valid = valid[0]; bus.ch0_in_data = din[0]; bus.ch0_out_ready = ready[0];
        bus.ch1_req = req[1]; bus.ch1_in_valid = valid[1]; bus.ch1_in_data = din[1]; bus.ch1_out_ready = ready[1];
        bus.core_end = cend;
    endtask

    task automatic compare_outputs();
        int o;
        bit loading, unl, hs, e_start;
        logic [31:0] e_col, e_wr, e_sel, e_out0, e_out1;
        o       = m_owner;
        loading = (o >= 0) && (m_loaded < 4);
        unl     = (o >= 0) && m_ended;
        hs      = 1'b0;
        if (loading) hs = valid[o];
        e_col   = hs ? (32'd1 << m_loaded) : 32'd0;
        e_wr    = hs ? din[o] : 32'd0;
        e_start = (o >= 0) && (m_loaded == 4) && !m_started;
        e_sel   = unl ? 32'(m_unloaded) : 32'd0;
        e_out0  = (unl && o == 0) ? result_mem[m_unloaded] : 32'd0;
        e_out1  = (unl && o == 1) ? result_mem[m_unloaded] : 32'd0;
        chk("ch0_gnt",       32'(bus.ch0_gnt),       32'(o == 0));
        chk("ch1_gnt",       32'(bus.ch1_gnt),       32'(o == 1));
        chk("ch0_in_ready",  32'(bus.ch0_in_ready),  32'(loading && o == 0));
        chk("ch1_in_ready",  32'(bus.ch1_in_ready),  32'(loading && o == 1));
        chk("ch0_out_valid", 32'(bus.ch0_out_valid), 32'(unl && o == 0));
        chk("ch1_out_valid", 32'(bus.ch1_out_valid), 32'(unl && o == 1));
        chk("ch0_out_data",  bus.ch0_out_data,       e_out0);
        chk("ch1_out_data",  bus.ch1_out_data,       e_out1);
        chk("core_col_en",   32'(bus.core_col_en),   e_col);
        chk("core_wr_data",  bus.core_wr_data,       e_wr);
        chk("core_rd_sel",   32'(bus.core_rd_sel),   e_sel);
        chk("core_start",    32'(bus.core_start),    32'(e_start));
        chk("err",           32'(bus.err),           32'(m_err));
    endtask

    task automatic observe();
        if (bus.core_col_en != 4'd0) begin
            col_q.push_back(bus.core_col_en);
            data_q.push_back(bus.core_wr_data);
        end
        if (bus.ch0_out_valid && bus.ch0_out_ready) out_q.push_back(bus.ch0_out_data);
        if (bus.ch1_out_valid && bus.ch1_out_ready) out_q.push_back(bus.ch1_out_data);
        if (bus.core_start) start_cnt++;
        if (bus.ch0_gnt && !prev_g0) gnt_q.push_back(0);
        if (bus.ch1_gnt && !prev_g1) gnt_q.push_back(1);
        if (bus.ch0_gnt) g0_cycles++;
        if (bus.ch0_out_valid && !bus.ch0_out_ready && bus.core_rd_sel == 2'd1) stall_cnt++;
        prev_g0  = bus.ch0_gnt;
        prev_g1  = bus.ch1_gnt;
        last_err = bus.err;
    endtask

    // Advance the model by one clock using the inputs present at the edge.
    task automatic model_step();
        if (!rst_n) begin
            m_valid = 1'b1; m_owner = -1; m_loaded = 0; m_unloaded = 0;
            m_started = 1'b0; m_ended = 1'b0; m_ptr = 0; m_waitc = 0; m_err = 1'b0;
            return;
        end
        if (!m_valid) return;
        if (m_owner < 0) begin
            if (req[0] || req[1]) begin
                m_owner = (req[0] && req[1]) ? m_ptr : (req[0] ? 0 : 1);
                m_loaded = 0; m_unloaded = 0; m_started = 1'b0; m_ended = 1'b0; m_err = 1'b0;
            end
        end else if (m_loaded < 4) begin
            if (valid[m_owner]) m_loaded++;
        end else if (!m_started) begin
            m_started = 1'b1;
            m_waitc = 0;
        end else if (!m_ended) begin
            if (cend) m_ended = 1'b1;
            else begin
                m_waitc++;
`ifdef AES_ARB_TIMEOUT_EN
                if (m_waitc == TIMEOUT) begin
                    m_err = 1'b1; m_ptr = 1 - m_owner; m_owner = -1; done_cnt++;
                end
`endif
            end
        end else if (ready[m_owner]) begin
            m_unloaded++;
            if (m_unloaded == 4) begin
                m_ptr = 1 - m_owner; m_owner = -1; done_cnt++;
            end
        end
    endtask

    task automatic run_cycle();
        drive();
        @(negedge clk);
        if (m_valid) begin
            compare_outputs();
            observe();
        end
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic run_until(input int target, input int budget, input string name);
        int n = 0;
        while (done_cnt < target && n < budget) begin
            run_cycle();
            n++;
        end
        chk(name, 32'(done_cnt >= target), 32'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        test_words[0] = 32'h0011_2233; test_words[1] = 32'h4455_6677;
        test_words[2] = 32'h8899_AABB; test_words[3] = 32'hCCDD_EEFF;
        result_mem[0] = 32'hA0A0_0000; result_mem[1] = 32'hB1B1_1111;
        result_mem[2] = 32'hC2C2_2222; result_mem[3] = 32'hD3D3_3333;

        // Reset
        k_rst = 1'b0;
        repeat (3) run_cycle();
        k_rst = 1'b1;
        chk("rst_ch0_gnt", 32'(bus.ch0_gnt), 32'd0);
        chk("rst_core_col_en", 32'(bus.core_col_en), 32'd0);

        // Single ch0 block with literal data, end_aes on the 20th WAIT cycle
        clear_obs();
        fixed_words = 1'b1; end_delay = 19; k_req = '{1, 0};
        run_until(1, 200, "t1_done");
        k_req = '{0, 0}; fixed_words = 1'b0;
        chk("t1_col_cnt", 32'(col_q.size()), 32'd4);
        chk("t1_out_cnt", 32'(out_q.size()), 32'd4);
        if (col_q.size() == 4 && out_q.size() == 4) begin
            chk("t1_col0", 32'(col_q[0]), 32'h1); chk("t1_col3", 32'(col_q[3]), 32'h8);
            chk("t1_col1", 32'(col_q[1]), 32'h2); chk("t1_col2", 32'(col_q[2]), 32'h4);
            chk("t1_wd0", data_q[0], 32'h0011_2233); chk("t1_wd3", data_q[3], 32'hCCDD_EEFF);
            chk("t1_rd0", out_q[0], 32'hA0A0_0000); chk("t1_rd3", out_q[3], 32'hD3D3_3333);
        end
        chk("t1_start_cnt", 32'(start_cnt), 32'd1);
        chk("t1_gnt_cycles", 32'(g0_cycles), 32'd29);
        run_cycle();
        chk("t1_gnt_dropped", 32'(bus.ch0_gnt), 32'd0);

        // Both requesting from reset: ch0, ch1, ch0
        for (int i = 0; i < 4; i++) result_mem[i] = $urandom();
        k_req = '{1, 1}; k_rst = 1'b0; run_cycle(); k_rst = 1'b1;
        clear_obs();
        p_valid = 70; p_ready = 80; end_delay = -1;
        base = done_cnt;
        run_until(base + 3, 600, "t2_done");
        chk("t2_gnt_cnt", 32'(gnt_q.size() >= 3), 32'd1);
        if (gnt_q.size() >= 3) begin
            chk("t2_gnt0", 32'(gnt_q[0]), 32'd0);
            chk("t2_gnt1", 32'(gnt_q[1]), 32'd1);
            chk("t2_gnt2", 32'(gnt_q[2]), 32'd0);
        end

        // Output stall on word 1
        k_req = '{0, 0}; k_rst = 1'b0; run_cycle(); k_rst = 1'b1;
        clear_obs();
        k_req = '{1, 0}; p_valid = 100; p_ready = 100; stall_left = 5; end_delay = 5;
        base = done_cnt;
        run_until(base + 1, 200, "t3_done");
        k_req = '{0, 0};
        chk("t3_stall_cycles", 32'(stall_cnt), 32'd5);
        chk("t3_out_cnt", 32'(out_q.size()), 32'd4);
        if (out_q.size() == 4) begin
            chk("t3_rd1", out_q[1], result_mem[1]);
            chk("t3_rd2", out_q[2], result_mem[2]);
        end

        // Input valid gaps with core_end noise during LOAD
        run_cycle();
        clear_obs();
        k_req = '{1, 0}; p_valid = 40; end_delay = -1;
        base = done_cnt;
        run_until(base + 1, 400, "t4_done");
        k_req = '{0, 0};
        chk("t4_col_cnt", 32'(col_q.size()), 32'd4);
        chk("t4_start_cnt", 32'(start_cnt), 32'd1);

        // Reset while waiting for end_aes
        run_cycle();
        k_req = '{1, 1}; p_valid = 100; end_delay = -2;
        for (int n = 0; n < 100 && !(m_started && !m_ended); n++) run_cycle();
        chk("t5_reached_wait", 32'(m_started && !m_ended), 32'd1);
        repeat (3) run_cycle();
        k_rst = 1'b0; run_cycle(); k_rst = 1'b1;
        chk("t5_gnt_after_rst", 32'({bus.ch1_gnt, bus.ch0_gnt}), 32'd0);
        clear_obs();
        end_delay = -1;
        base = done_cnt;
        run_until(base + 1, 400, "t5_done");
        chk("t5_first_gnt_ch0", 32'((gnt_q.size() > 0) ? gnt_q[0] : -1), 32'd0);

        // Random soak
        k_req = '{2, 2}; p_valid = 60; p_ready = 60; end_delay = -1;
        repeat (1500) run_cycle();

`ifdef AES_ARB_TIMEOUT_EN
        // end_aes never arrives: abort, then ch1 takes the next grant
        k_req = '{0, 0}; k_rst = 1'b0; run_cycle(); k_rst = 1'b1;
        clear_obs();
        k_req = '{1, 0}; p_valid = 100; p_ready = 100; end_delay = -2;
        base = done_cnt;
        run_until(base + 1, 200, "t6_abort");
        chk("t6_no_words", 32'(out_q.size()), 32'd0);
        k_req = '{0, 1}; end_delay = 3;
        gnt_q.delete();
        run_cycle();
        chk("t6_err_set", 32'(last_err), 32'd1);
        run_until(base + 2, 200, "t6_ch1_done");
        chk("t6_next_gnt_ch1", 32'((gnt_q.size() > 0) ? gnt_q[0] : -1), 32'd1);
        chk("t6_err_cleared", 32'(bus.err), 32'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/aes_core_arbiter.md
Name: aes_core_arbiter

Overview:
Shares the single AES datapath between two word-serial requesters (channel 0 and channel 1). The arbiter grants the core to one channel for one full 128-bit block transaction: load 4 words, start the core, wait for end of processing, then unload 4 words. Grants alternate round-robin. The block sits between the host/DMA front ends and the datapath's host-side column write/read ports and its end_aes flag.

Parameters:
TIMEOUT, 64, maximum cycles allowed in WAIT before abort (used only with the optional feature)
TMR_W, 7, width of the wait-cycle counter; must hold TIMEOUT

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  reset, synchronous, active-low
ch0_req  in  1  channel 0 requests one block transaction
ch0_gnt  out  1  channel 0 owns the core
ch0_in_valid  in  1  channel 0 input word valid
ch0_in_data  in  32  channel 0 input word
ch0_in_ready  out  1  arbiter accepts a channel 0 input word
ch0_out_valid  out  1  channel 0 result word valid
ch0_out_data  out  32  channel 0 result word
ch0_out_ready  in  1  channel 0 accepts a result word
ch1_*  (same 8 ports as ch0_*, same widths and directions)  channel 1
core_wr_data  out  32  word written to the datapath column
core_col_en  out  4  one-hot column write enable, bit i writes column i
core_rd_sel  out  2  column index read back from the datapath
core_rd_data  in  32  column read data, combinational from core_rd_sel
core_start  out  1  one-cycle pulse: start block processing
core_end  in  1  datapath end-of-block flag (end_aes)
err  out  1  sticky abort flag (optional feature only; tied 0 otherwise)

Behaviour:
- Reset (rst_n=0 at a clk edge): state=IDLE, all outputs 0, word index=0, priority pointer=ch0, timer=0. Reset mid-transaction aborts immediately with no output words. The core is not notified.
- States: IDLE, LOAD, START, WAIT, UNLOAD.
- IDLE: requests are sampled here only.
  - If both reqs are high, grant the channel named by the priority pointer.
  - If one req is high, grant that channel.
  - gnt is registered and asserts the cycle after req is seen; the state moves to LOAD in the same cycle.
- LOAD: granted channel's in_ready=1.
  - Each handshake (valid & ready) drives core_col_en=1<<idx and core_wr_data=in_data in the same cycle (combinational), then increments idx.
  - Columns are written in order 0,1,2,3.
  - No write occurs in a cycle where valid=0.
  - After the word at idx=3, idx wraps to 0 and the state moves to START.
- START: core_start=1 for exactly one cycle, then WAIT.
- WAIT: holds until core_end=1, then UNLOAD.
  - core_end seen during LOAD or START is ignored.
- UNLOAD: granted channel's out_valid=1, out_data=core_rd_data, core_rd_sel=idx.
  - Values hold stable while valid & !ready.
  - idx advances on each handshake.
  - After the handshake at idx=3: idx=0, gnt drops the next cycle, the priority pointer moves to the other channel, and the state returns to IDLE.
- Non-granted channel: in_ready=0, out_valid=0, gnt=0 throughout.
- The granted channel dropping req mid-transaction is ignored; the transaction completes.
- Minimum occupancy: 1 (grant) + 4 (load) + 1 (start) + core latency + 4 (unload) cycles.
- Back-to-back: the earliest next gnt is 1 cycle after IDLE is re-entered. With both channels requesting continuously, grants strictly alternate.
- gnt, core_start, state, idx and timer are registers. Handshake outputs are decoded from state and gnt.

Optional Feature:
Macro AES_ARB_TIMEOUT_EN.
- Enabled: the timer clears on entry to WAIT and increments each WAIT cycle.
  - If it reaches TIMEOUT with core_end=0: err is set, the state goes to IDLE, gnt drops, no result words are produced, and priority passes to the other channel.
  - err stays set until the next grant is issued (cleared in the grant cycle).
  - core_end and timer expiry in the same cycle: core_end wins, no error.
- Disabled: no timer logic, err tied 0, WAIT is unbounded.

Test Plan:
- Reset then ch0_req=1 with words 0x00112233, 0x44556677, 0x8899AABB, 0xCCDDEEFF, core_end after 20 cycles → core_col_en pulses 0001, 0010, 0100, 1000 with matching data. core_start pulses once. The 4 result words equal core_rd_data for sel 0..3. ch0_gnt drops after the 4th word.
- ch0_req and ch1_req both high from reset → ch0 served first, then ch1, then ch0. ch1 in_ready/out_valid stay 0 while ch0 is granted.
- ch0 out_ready held 0 for 5 cycles during UNLOAD of word 1 → out_data stays stable, core_rd_sel stays 1, no word is skipped.
- ch0 in_valid gaps (valid toggling) during LOAD → exactly 4 column writes; core_start only after the 4th. core_end pulsed during LOAD is ignored.
- rst_n=0 for 1 cycle while in WAIT → next cycle all outputs 0, state IDLE, priority back to ch0.
- With AES_ARB_TIMEOUT_EN, TIMEOUT=64, core_end never asserted → err=1 after 64 WAIT cycles, gnt drops, zero result words, the next grant goes to ch1 and clears err.
